// File: rtl/oled_pkg.sv
// Shared constants, FSM encoding and payload types for the OLED framebuffer.
// The storage is page-organised: one byte holds eight vertically stacked pixels.
package oled_pkg;

    localparam int unsigned DISPLAY_WIDTH  = 128;
    localparam int unsigned DISPLAY_HEIGHT = 64;
    localparam int unsigned PAGES          = DISPLAY_HEIGHT / 8;
    localparam int unsigned FB_ADDR_W      = 10;
    localparam int unsigned COL_W          = 7;
    localparam int unsigned ROW_W          = 6;
    localparam int unsigned PAGE_W         = 3;
    localparam int unsigned BYTE_W         = 8;

    typedef enum logic [2:0] {
        INIT_CLEAR = 3'd0,
        IDLE       = 3'd1,
        RMW_READ   = 3'd2,
        RMW_WRITE  = 3'd3,
        CLEAR      = 3'd4
    } fb_state_t;

    typedef struct packed {
        logic [COL_W-1:0] x;
        logic [ROW_W-1:0] y;
        logic             on;
    } px_req_t;

    // Byte address of a pixel: page (upper row bits) concatenated with column.
    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [ROW_W-1:0] y,
                                                     input logic [COL_W-1:0] x);
        return {y[ROW_W-1:3], x};
    endfunction

    function automatic logic [BYTE_W-1:0] set_bit(input logic [BYTE_W-1:0] b,
                                                   input logic [2:0]        n,
                                                   input logic              v);
        logic [BYTE_W-1:0] r;
        r    = b;
        r[n] = v;
        return r;
    endfunction

endpackage

// File: rtl/oled_framebuffer_if.sv
// Pixel-write, fill and display-read signals of the OLED framebuffer.
interface oled_framebuffer_if;
    import oled_pkg::*;

    logic              px_valid;
    logic              px_ready;
    logic [COL_W-1:0]  px_x;
    logic [ROW_W-1:0]  px_y;
    logic              px_on;
    logic              clr_req;
    logic              clr_value;
    logic              busy;
    logic              rd_en;
    logic [PAGE_W-1:0] rd_page;
    logic [COL_W-1:0]  rd_col;
    logic [BYTE_W-1:0] rd_data;
    logic              rd_valid;

    modport slave (
        input  px_valid, px_x, px_y, px_on, clr_req, clr_value,
        input  rd_en, rd_page, rd_col,
        output px_ready, busy, rd_data, rd_valid
    );

    modport master (
        output px_valid, px_x, px_y, px_on, clr_req, clr_value,
        output rd_en, rd_page, rd_col,
        input  px_ready, busy, rd_data, rd_valid
    );

endinterface

// File: rtl/oled_fb_ram.sv
// Dual-port byte RAM: port A is a registered read for the display driver,
// port B is read/write for the update FSM (reads return pre-write contents).
module oled_fb_ram
    import oled_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_a_en,
    input  logic [AW-1:0]     i_a_addr,
    output logic [BYTE_W-1:0] o_a_data,
    input  logic              i_b_we,
    input  logic [AW-1:0]     i_b_addr,
    input  logic [BYTE_W-1:0] i_b_wdata,
    output logic [BYTE_W-1:0] o_b_rdata
);

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [BYTE_W-1:0] r_a_data;
    logic [BYTE_W-1:0] r_b_rdata;

    // Storage and FSM port; contents are only initialised by the clear sequence.
    always_ff @(posedge clk) begin
        if (i_b_we) begin
            r_mem[i_b_addr] <= i_b_wdata;
        end
        r_b_rdata <= r_mem[i_b_addr];
    end

    // Driver port holds its last byte between strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_data <= '0;
        end else if (i_a_en) begin
            r_a_data <= r_mem[i_a_addr];
        end
    end

    assign o_a_data  = r_a_data;
    assign o_b_rdata = r_b_rdata;

endmodule

// File: rtl/oled_framebuffer.sv
// SSD1306-style page framebuffer: single-pixel read-modify-write updates,
// whole-screen fills, and an independent one-cycle-latency driver read port.
module oled_framebuffer #(
    parameter int unsigned DISPLAY_WIDTH  = oled_pkg::DISPLAY_WIDTH,
    parameter int unsigned DISPLAY_HEIGHT = oled_pkg::DISPLAY_HEIGHT
) (
    input  logic              clk,
    input  logic              reset_n,
    oled_framebuffer_if.slave fb
);
    import oled_pkg::*;

    localparam int unsigned FB_DEPTH = (DISPLAY_WIDTH * DISPLAY_HEIGHT) / 8;

    fb_state_t             r_state;
    fb_state_t             w_state_next;
    logic [FB_ADDR_W-1:0]  r_cnt;
    logic [FB_ADDR_W-1:0]  w_cnt_next;
    logic                  w_cnt_last;
    logic                  w_cnt_run;
    px_req_t               r_px;
    logic                  r_fill;
    logic                  w_load_px;
    logic                  w_load_clr;
    logic                  r_px_ready;
    logic                  r_busy;
    logic                  r_rd_valid;
    logic                  w_b_we;
    logic [FB_ADDR_W-1:0]  w_b_addr;
    logic [BYTE_W-1:0]     w_b_wdata;
    logic [BYTE_W-1:0]     w_b_rdata;

    // The clear sweep ends on the natural wrap of the address counter.
    assign w_cnt_next = r_cnt + FB_ADDR_W'(1);
    assign w_cnt_last = (w_cnt_next == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= INIT_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_b_we       = 1'b0;
        w_b_addr     = fb_addr(r_px.y, r_px.x);
        w_b_wdata    = '0;
        w_load_px    = 1'b0;
        w_load_clr   = 1'b0;
        w_cnt_run    = 1'b0;
        unique case (r_state)
            INIT_CLEAR: begin
                w_b_we    = 1'b1;
                w_b_addr  = r_cnt;
                w_b_wdata = '0;
                w_cnt_run = 1'b1;
                if (w_cnt_last) begin
                    w_state_next = IDLE;
                end
            end
            IDLE: begin
                // A fill request wins over a simultaneous pixel write.
                if (fb.clr_req) begin
                    w_load_clr   = 1'b1;
                    w_state_next = CLEAR;
                end else if (fb.px_valid) begin
                    w_load_px    = 1'b1;
                    w_state_next = RMW_READ;
                end
            end
            RMW_READ: begin
                w_state_next = RMW_WRITE;
            end
            RMW_WRITE: begin
                w_b_we       = 1'b1;
                w_b_wdata    = set_bit(w_b_rdata, r_px.y[2:0], r_px.on);
                w_state_next = IDLE;
            end
            CLEAR: begin
                w_b_we    = 1'b1;
                w_b_addr  = r_cnt;
                w_b_wdata = {BYTE_W{r_fill}};
                w_cnt_run = 1'b1;
                if (w_cnt_last) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = INIT_CLEAR;
            end
        endcase
    end

    // Clear address counter; it is back at zero whenever a sweep completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_cnt_run) begin
            r_cnt <= w_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_px   <= '0;
            r_fill <= 1'b0;
        end else begin
            if (w_load_px) begin
                r_px <= '{x: fb.px_x, y: fb.px_y, on: fb.px_on};
            end
            if (w_load_clr) begin
                r_fill <= fb.clr_value;
            end
        end
    end

    // Handshake flags are registered copies of the next-state decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_px_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_rd_valid <= 1'b0;
        end else begin
            r_px_ready <= (w_state_next == IDLE);
            r_busy     <= (w_state_next != IDLE);
            r_rd_valid <= fb.rd_en;
        end
    end

    assign fb.px_ready = r_px_ready;
    assign fb.busy     = r_busy;
    assign fb.rd_valid = r_rd_valid;

    oled_fb_ram #(
        .DEPTH (FB_DEPTH),
        .AW    (FB_ADDR_W)
    ) u_ram (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_a_en    (fb.rd_en),
        .i_a_addr  ({fb.rd_page, fb.rd_col}),
        .o_a_data  (fb.rd_data),
        .i_b_we    (w_b_we),
        .i_b_addr  (w_b_addr),
        .i_b_wdata (w_b_wdata),
        .o_b_rdata (w_b_rdata)
    );

endmodule

// File: tb/tb_oled_framebuffer.sv
// Randomised bench for oled_framebuffer against a pixel-level model of the
// display, plus fixed scenarios with hand-computed byte values.
module tb_oled_framebuffer;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    oled_framebuffer_if fb();

    oled_framebuffer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .fb      (fb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: a 128x64 pixel grid ----------------
    typedef enum int {M_IDLE, M_PIX, M_FILL} mmode_t;

    bit          pix   [128][64];
    bit          known [1024];
    mmode_t      m_mode;
    int          m_left;
    bit          m_fill;
    int          m_px_x;
    int          m_px_y;
    bit          m_px_on;
    logic [7:0]  m_rd_data;
    bit          m_rd_known;
    bit          m_rd_valid;
    bit          m_busy;

    function automatic logic [7:0] byte_of(input int page, input int col);
        logic [7:0] b;
        for (int n = 0; n < 8; n++) b[n] = pix[col][page * 8 + n];
        return b;
    endfunction

    task automatic model_step();
        int idx;
        if (!reset_n) begin
            m_mode     = M_FILL;
            m_fill     = 1'b0;
            m_left     = 1024;
            m_rd_data  = 8'h00;
            m_rd_known = 1'b1;
            m_rd_valid = 1'b0;
        end else begin
            m_rd_valid = fb.rd_en;
            if (fb.rd_en) begin
                idx        = int'(fb.rd_page) * 128 + int'(fb.rd_col);
                m_rd_data  = byte_of(int'(fb.rd_page), int'(fb.rd_col));
                m_rd_known = known[idx];
            end
            if (m_mode == M_IDLE) begin
                if (fb.clr_req) begin
                    m_mode = M_FILL;
                    m_fill = fb.clr_value;
                    m_left = 1024;
                end else if (fb.px_valid) begin
                    m_mode  = M_PIX;
                    m_left  = 2;
                    m_px_x  = int'(fb.px_x);
                    m_px_y  = int'(fb.px_y);
                    m_px_on = fb.px_on;
                end
            end else begin
                if (m_mode == M_PIX) begin
                    if (m_left == 1) pix[m_px_x][m_px_y] = m_px_on;
                end else begin
                    idx = 1024 - m_left;
                    for (int n = 0; n < 8; n++) pix[idx % 128][(idx / 128) * 8 + n] = m_fill;
                    known[idx] = 1'b1;
                end
                m_left--;
                if (m_left == 0) m_mode = M_IDLE;
            end
        end
        m_busy = (m_mode != M_IDLE);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            model_step();
        end
    end

    // Every-cycle comparison, sampled mid-cycle after all updates settle.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            chk("busy", 32'(fb.busy), 32'(m_busy));
            chk("px_ready", 32'(fb.px_ready), 32'(!m_busy));
            chk("rd_valid", 32'(fb.rd_valid), 32'(m_rd_valid));
            if (m_rd_known) chk("rd_data", 32'(fb.rd_data), 32'(m_rd_data));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers (entered and left on a negedge) ----------------
    task automatic count_busy(output int n);
        n = 0;
        while (fb.busy && n < 3000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!fb.px_ready && n < 3000) begin
            n++;
            @(negedge clk);
        end
        chk("idle_wait", 32'(fb.px_ready), 32'd1);
    endtask

    task automatic rd_check(input string name, input int page, input int col, input logic [7:0] exp);
        fb.rd_en   = 1'b1;
        fb.rd_page = 3'(page);
        fb.rd_col  = 7'(col);
        @(negedge clk);
        fb.rd_en = 1'b0;
        chk(name, 32'(fb.rd_data), 32'(exp));
    endtask

    task automatic sweep(input string name, input logic [7:0] exp);
        int nbad;
        nbad = bad;
        for (int i = 0; i < 1024; i++) begin
            fb.rd_en   = 1'b1;
            fb.rd_page = 3'(i / 128);
            fb.rd_col  = 7'(i % 128);
            @(negedge clk);
            chk(name, 32'(fb.rd_data), 32'(exp));
            if (bad - nbad > 8) break;
        end
        fb.rd_en = 1'b0;
    endtask

    task automatic send_px(input int x, input int y, input bit on);
        wait_idle();
        fb.px_valid = 1'b1;
        fb.px_x     = 7'(x);
        fb.px_y     = 6'(y);
        fb.px_on    = on;
        @(negedge clk);
        fb.px_valid = 1'b0;
        wait_idle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int         n;
        logic [7:0] seq [4];
        total        = 0;
        bad          = 0;
        reset_n      = 1'b0;
        fb.px_valid  = 1'b0;
        fb.px_x      = '0;
        fb.px_y      = '0;
        fb.px_on     = 1'b0;
        fb.clr_req   = 1'b0;
        fb.clr_value = 1'b0;
        fb.rd_en     = 1'b0;
        fb.rd_page   = '0;
        fb.rd_col    = '0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(fb.busy), 32'd1);
        chk("rst_px_ready", 32'(fb.px_ready), 32'd0);
        chk("rst_rd_valid", 32'(fb.rd_valid), 32'd0);
        chk("rst_rd_data", 32'(fb.rd_data), 32'h00);
        reset_n = 1'b1;
        count_busy(n);
        chk("init_busy_cycles", 32'(n), 32'd1024);
        chk("init_ready", 32'(fb.px_ready), 32'd1);
        sweep("init_sweep", 8'h00);

        // Reads every cycle across an RMW of page 2 column 3 (row 17 -> bit 1).
        wait_idle();
        fb.px_valid = 1'b1;
        fb.px_x     = 7'd3;
        fb.px_y     = 6'd17;
        fb.px_on    = 1'b1;
        fb.rd_en    = 1'b1;
        fb.rd_page  = 3'd2;
        fb.rd_col   = 7'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            fb.px_valid = 1'b0;
            seq[i] = fb.rd_data;
        end
        fb.rd_en = 1'b0;
        chk("rmw_rd_accept", 32'(seq[0]), 32'h00);
        chk("rmw_rd_read", 32'(seq[1]), 32'h00);
        chk("rmw_rd_write_cycle_old", 32'(seq[2]), 32'h00);
        chk("rmw_rd_after_new", 32'(seq[3]), 32'h02);

        // Single pixel latency and byte placement.
        wait_idle();
        fb.px_valid = 1'b1;
        fb.px_x     = 7'd5;
        fb.px_y     = 6'd10;
        fb.px_on    = 1'b1;
        @(negedge clk);
        fb.px_valid = 1'b0;
        count_busy(n);
        chk("px_busy_cycles", 32'(n), 32'd2);
        rd_check("px_p1c5", 1, 5, 8'h04);
        rd_check("px_p0c5", 0, 5, 8'h00);

        send_px(0, 0, 1'b1);
        send_px(0, 7, 1'b1);
        send_px(0, 0, 1'b0);
        rd_check("px_p0c0", 0, 0, 8'h80);

        // Fill request and pixel in the same cycle: the fill wins.
        wait_idle();
        fb.clr_req   = 1'b1;
        fb.clr_value = 1'b1;
        fb.px_valid  = 1'b1;
        fb.px_x      = 7'd9;
        fb.px_y      = 6'd9;
        fb.px_on     = 1'b0;
        @(negedge clk);
        fb.clr_req  = 1'b0;
        fb.px_valid = 1'b0;
        count_busy(n);
        chk("clr_busy_cycles", 32'(n), 32'd1024);
        sweep("clr_ff_sweep", 8'hFF);

        // Randomised traffic against the model.
        for (int c = 0; c < 2500; c++) begin
            fb.px_valid  = ($urandom_range(0, 2) != 0);
            fb.px_x      = 7'($urandom);
            fb.px_y      = 6'($urandom);
            fb.px_on     = 1'($urandom);
            fb.rd_en     = 1'($urandom);
            fb.rd_page   = 3'($urandom);
            fb.rd_col    = 7'($urandom);
            fb.clr_req   = ($urandom_range(0, 599) == 0);
            fb.clr_value = 1'($urandom);
            @(negedge clk);
        end
        fb.px_valid = 1'b0;
        fb.rd_en    = 1'b0;
        fb.clr_req  = 1'b0;
        wait_idle();

        // Reset in the middle of a 0xFF fill.
        fb.clr_req   = 1'b1;
        fb.clr_value = 1'b1;
        @(negedge clk);
        fb.clr_req = 1'b0;
        repeat (300) @(negedge clk);
        chk("mid_clr_busy", 32'(fb.busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_busy", 32'(fb.busy), 32'd1);
        chk("abort_px_ready", 32'(fb.px_ready), 32'd0);
        chk("abort_rd_valid", 32'(fb.rd_valid), 32'd0);
        chk("abort_rd_data", 32'(fb.rd_data), 32'h00);
        @(negedge clk);
        reset_n = 1'b1;
        count_busy(n);
        chk("reinit_busy_cycles", 32'(n), 32'd1024);
        sweep("reinit_sweep", 8'h00);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/oled_framebuffer.md
OLED_FRAMEBUFFER -- requirements
Module: oled_framebuffer

Interface
REQ-001 Parameter: DISPLAY_WIDTH, default 128, pixel columns.
REQ-002 Parameter: DISPLAY_HEIGHT, default 64, pixel rows (multiple of 8).
REQ-003 Port: clk, input, 1, single clock for the block.
REQ-004 Port: reset_n, input, 1, asynchronous active-low reset.
REQ-005 Port: px_valid, input, 1, pixel write request.
REQ-006 Port: px_ready, output, 1, pixel write accepted when high with px_valid.
REQ-007 Port: px_x, input, 7, pixel column 0..127.
REQ-008 Port: px_y, input, 6, pixel row 0..63.
REQ-009 Port: px_on, input, 1, pixel value (1 = lit).
REQ-010 Port: clr_req, input, 1, fill-screen request (level, sampled in IDLE).
REQ-011 Port: clr_value, input, 1, fill value (0 gives 0x00, 1 gives 0xFF).
REQ-012 Port: busy, output, 1, high during any clear or read-modify-write.
REQ-013 Port: rd_en, input, 1, display-driver byte read strobe.
REQ-014 Port: rd_page, input, 3, page 0..7.
REQ-015 Port: rd_col, input, 7, column 0..127.
REQ-016 Port: rd_data, output, 8, page byte; bit n = row rd_page*8+n (LSB = top row).
REQ-017 Port: rd_valid, output, 1, rd_data valid strobe.

Function
REQ-018 Storage: 1024 x 8 bytes, address = {page, column}, page-organized to match SSD1306 horizontal addressing.
REQ-019 Read port: independent of write FSM; rd_en at cycle N -> rd_data and rd_valid at N+1; rd_valid is a 1-cycle pulse per rd_en; rd_data holds its value otherwise.
REQ-020 Read and write to the same address in the same cycle: rd_data returns the old byte.
REQ-021 FSM states: INIT_CLEAR, IDLE, RMW_READ, RMW_WRITE, CLEAR.
REQ-022 INIT_CLEAR: entered on reset; writes 0x00 to addresses 0..1023, one per cycle; then IDLE.
REQ-023 IDLE: px_ready = 1 and busy = 0; px_ready = 0 in every other state.
REQ-024 IDLE with clr_req = 1: latch clr_value, go to CLEAR; clr_req has priority over px_valid in the same cycle, and that pixel is not accepted.
REQ-025 CLEAR: writes the fill byte to addresses 0..1023, one per cycle (1024 cycles), then IDLE.
REQ-026 IDLE with px_valid = 1 and clr_req = 0: latch x, y and on; addr = {y[5:3], x}; bit = y[2:0]; go to RMW_READ.
REQ-027 RMW_READ: issue read of addr; go to RMW_WRITE.
REQ-028 RMW_WRITE: write the read byte with the selected bit set to the latched on value; go to IDLE.
REQ-029 Pixel throughput: one pixel per 3 cycles; a held px_valid is accepted again on each return to IDLE.
REQ-030 clr_req or px_valid outside IDLE: ignored; no queuing.
REQ-031 Clear address counter: 10 bits; the wrap from 1023 to 0 terminates the clear.

Reset
REQ-032 Asynchronous reset state: INIT_CLEAR, counter 0, px_ready = 0, busy = 1, rd_valid = 0, rd_data = 0x00.
REQ-033 Reset asserted mid-RMW or mid-clear aborts the operation immediately; the full INIT_CLEAR sequence reruns after release.
REQ-034 Memory contents are not reset directly; only INIT_CLEAR initializes them.

Structure
REQ-035 Shared package oled_pkg holds DISPLAY_WIDTH, DISPLAY_HEIGHT, PAGES = HEIGHT/8, FB_ADDR_W = 10, and the FSM state encoding.
REQ-036 One sub-module, oled_fb_ram: 1024x8 dual-port RAM with a registered read port A for the driver and a read/write port B for the FSM.

Verification
REQ-037 Reset release: busy is high for 1024 cycles, then px_ready = 1; read of every address returns 0x00.
REQ-038 Pixel (x=5, y=10, on=1): after 3 cycles busy = 0; read page 1, col 5 returns 0x04; page 0, col 5 returns 0x00.
REQ-039 Pixels (0,0,1) then (0,7,1) then (0,0,0): read page 0, col 0 returns 0x80.
REQ-040 clr_req = 1 with clr_value = 1 and px_valid = 1 in the same cycle: pixel not accepted; after 1024 cycles every byte = 0xFF.
REQ-041 rd_en every cycle during an RMW to page 2, col 3: the read in the write cycle returns the old byte; the next read returns the new byte.
REQ-042 reset_n pulsed low mid-CLEAR (fill 0xFF): outputs take reset values at once; after re-init all bytes = 0x00.
